button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, 4, cycles a synchronized input must stay stable to be accepted (legal range 2..65535).
REQ-002 SHALL have parameter LONG_CYCLES, 16, cycles a debounced toggle press must be held to count as a long press (legal range > DEBOUNCE_CYCLES).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_toggle_raw  input  1  asynchronous, bouncing start/stop button, high = pressed.
REQ-006 SHALL have port btn_clear_raw  input  1  asynchronous, bouncing clear button, high = pressed.
REQ-007 SHALL have port toggle  output  1  one-cycle pulse per accepted toggle press; drives the stopwatch toggle input.
REQ-008 SHALL have port clear  output  1  one-cycle pulse per accepted clear event; drives the stopwatch reset input.

Function
REQ-009 SHALL pass each raw input through its own 2-flop synchronizer before any other use.
REQ-010 SHALL run one debounce FSM per button with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-011 IDLE: synchronized input high -> PRESS_WAIT with stability counter cleared; otherwise stay.
REQ-012 PRESS_WAIT: input low -> IDLE; input high -> counter increments; counter reaching DEBOUNCE_CYCLES-1 while high -> PRESSED and fire a press event.
REQ-013 PRESSED: input low -> RELEASE_WAIT with counter cleared; no further press events while in PRESSED.
REQ-014 RELEASE_WAIT: input high -> PRESSED (bounce on release, no new event); input low for DEBOUNCE_CYCLES cycles -> IDLE.
REQ-015 Stability counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and SHALL saturate, never wrap.
REQ-016 toggle and clear SHALL be registered outputs, high for exactly one clk cycle per press event.
REQ-017 Latency: raw input held high from edge 0 SHALL give the pulse at edge DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES + 1 output register).
REQ-018 A raw high shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse.
REQ-019 Both buttons are independent; simultaneous accepted presses SHALL assert toggle and clear in the same cycle (downstream gives clear priority).
REQ-020 Holding a button indefinitely SHALL produce exactly one pulse until release is accepted.

Reset
REQ-021 reset SHALL asynchronously force synchronizer flops to 0, FSMs to IDLE, all counters to 0, toggle and clear to 0.
REQ-022 Reset asserted mid-press SHALL discard the press; after reset release a still-held button SHALL be re-debounced from IDLE and produce one pulse at the REQ-017 latency.

Configuration
REQ-023 Macro BUTTON_COND_LONGPRESS_EN SHALL compile in long-press clear.
REQ-024 With the macro: toggle channel in PRESSED for LONG_CYCLES consecutive cycles SHALL fire one clear pulse (once per press, saturating long counter, cleared on leaving PRESSED); clear = registered OR of clear-button event and long-press event.
REQ-025 Without the macro: no long counter is synthesized, LONG_CYCLES is ignored, clear comes only from btn_clear_raw.

Structure
REQ-026 Package button_cond_pkg SHALL hold the FSM state enum type and the default DEBOUNCE_CYCLES/LONG_CYCLES constants.
REQ-027 Sub-module debounce_channel (synchronizer + FSM + counter, outputs press event and pressed level) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-028 btn_toggle_raw high from edge 0, held 30 cycles -> toggle high only at edge 7; clear stays 0 (macro off).
REQ-029 btn_toggle_raw bounces high 2 cycles / low 1 cycle x5, then steady high -> exactly one toggle pulse, 7 edges after steady high begins.
REQ-030 Release bounce: after accepted press, raw low 2 cycles, high 1, then low -> no second pulse; FSM back to IDLE.
REQ-031 Both raw inputs rise same edge -> toggle and clear both high at edge 7.
REQ-032 reset pulsed at edge 5 of a press, button held -> no pulse before reset release; one pulse 7 edges after reset deasserts.
REQ-033 Macro on, toggle held 40 cycles -> toggle at edge 7, single clear pulse at edge 7+16 = 23, nothing further.

Source files
------------

// File: rtl/button_cond_pkg.sv
// -----------------------------------------------------------------------------
// button_cond_pkg
// Purpose : Shared types and default constants for the button conditioner.
//           Holds the debounce FSM state encoding and the default debounce /
//           long-press durations used by button_conditioner and
//           debounce_channel.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package button_cond_pkg;

    // Debounce FSM states, shared by every debounce_channel instance.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    // Cycles a synchronized input must stay stable to be accepted.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Cycles a debounced toggle press must be held to count as a long press.
    localparam int DEFAULT_LONG_CYCLES = 16;

endpackage : button_cond_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Purpose : Conditions one raw, bouncing, asynchronous push button.
//           2-flop synchronizer -> 4-state debounce FSM with a saturating
//           stability counter. Emits a single-cycle press event when a press
//           is accepted and a level that is high while the FSM sits in PRESSED.
// Ports   :
//   clk       in  1  rising-edge clock
//   reset     in  1  asynchronous, active-high reset
//   btn_raw   in  1  raw button, high = pressed
//   press_evt out 1  registered one-cycle pulse per accepted press
//   pressed   out 1  registered level, high while in PRESSED
// -----------------------------------------------------------------------------
module debounce_channel
    import button_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_evt,
    output logic pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic       sync1_r;
    logic       sync2_r;
    deb_state_t state_r;
    logic [CW-1:0] cnt_r;
    logic       press_evt_r;
    logic       pressed_r;

    // Saturating increment: the stability counter never wraps.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Two-flop synchronizer for the asynchronous raw button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM, stability counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            press_evt_r <= 1'b0;
            pressed_r   <= 1'b0;
        end else begin
            press_evt_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sync2_r) begin
                        state_r <= PRESS_WAIT;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_r) begin
                        state_r <= IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        // Stable long enough: accept and fire exactly once.
                        state_r     <= PRESSED;
                        press_evt_r <= 1'b1;
                        pressed_r   <= 1'b1;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                PRESSED: begin
                    if (!sync2_r) begin
                        state_r   <= RELEASE_WAIT;
                        cnt_r     <= CNT_ZERO;
                        pressed_r <= 1'b0;
                    end else begin
                        state_r <= PRESSED;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_r) begin
                        // Bounce on release: go back without a new event.
                        state_r   <= PRESSED;
                        pressed_r <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    pressed_r <= 1'b0;
                end
            endcase
        end
    end

    assign press_evt = press_evt_r;
    assign pressed   = pressed_r;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Purpose : Front end for a stopwatch. Debounces a start/stop button and a
//           clear button and turns each accepted press into a one-cycle pulse.
//           Optional long-press clear: define BUTTON_COND_LONGPRESS_EN so that
//           holding the toggle button for LONG_CYCLES cycles in its pressed
//           state also fires one clear pulse. Without the macro no long-press
//           logic exists and LONG_CYCLES is ignored.
// Ports   :
//   clk            in  1  rising-edge clock
//   reset          in  1  asynchronous, active-high reset
//   btn_toggle_raw in  1  raw start/stop button, high = pressed
//   btn_clear_raw  in  1  raw clear button, high = pressed
//   toggle         out 1  registered one-cycle pulse per accepted toggle press
//   clear          out 1  registered one-cycle pulse per accepted clear event
// -----------------------------------------------------------------------------
module button_conditioner
    import button_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_toggle_raw,
    input  logic btn_clear_raw,
    output logic toggle,
    output logic clear
);

    logic tog_evt_s;
    logic tog_pressed_s;
    logic clr_evt_s;
    logic clr_pressed_s;
    logic long_evt_s;
    logic toggle_r;
    logic clear_r;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_tog_chan (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_toggle_raw),
        .press_evt (tog_evt_s),
        .pressed   (tog_pressed_s)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_chan (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_clear_raw),
        .press_evt (clr_evt_s),
        .pressed   (clr_pressed_s)
    );

`ifdef BUTTON_COND_LONGPRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LONG_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);

    logic [LW-1:0] long_cnt_r;
    logic          long_evt_r;

    // Long-press detector: counts consecutive PRESSED cycles of the toggle
    // channel; parks at LONG_MAX after firing so it fires once per press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            long_cnt_r <= LONG_ZERO;
            long_evt_r <= 1'b0;
        end else begin
            long_evt_r <= 1'b0;
            if (!tog_pressed_s) begin
                long_cnt_r <= LONG_ZERO;
            end else if (long_cnt_r == LONG_LAST) begin
                long_cnt_r <= LONG_MAX;
                long_evt_r <= 1'b1;
            end else if (long_cnt_r != LONG_MAX) begin
                long_cnt_r <= long_cnt_r + LONG_ONE;
            end else begin
                long_cnt_r <= long_cnt_r;
            end
        end
    end

    assign long_evt_s = long_evt_r;
`else
    assign long_evt_s = 1'b0;
`endif

    // Output registers; clear merges the clear button and long-press events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle_r <= 1'b0;
            clear_r  <= 1'b0;
        end else begin
            toggle_r <= tog_evt_s;
            clear_r  <= clr_evt_s | long_evt_s;
        end
    end

    assign toggle = toggle_r;
    assign clear  = clear_r;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed stimulus tables for button_conditioner (DEBOUNCE_CYCLES=4,
// LONG_CYCLES=16). Edge 0 of each window is the first rising edge after the
// window's first raw value is applied; outputs are sampled 1 time unit after
// each rising edge. Expected pulse edges are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_button_conditioner;
    import button_cond_pkg::*;

`ifdef BUTTON_COND_LONGPRESS_EN
    localparam int HOLD40_CLR_EDGE = 23;
`else
    localparam int HOLD40_CLR_EDGE = -1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_toggle_raw;
    logic btn_clear_raw;
    logic toggle;
    logic clear;

    int checks = 0;
    int errors = 0;

    logic tog_pat [0:63];
    logic clr_pat [0:63];
    logic rst_pat [0:63];

    int tog_cnt;
    int tog_edge;
    int clr_cnt;
    int clr_edge;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_toggle_raw (btn_toggle_raw),
        .btn_clear_raw  (btn_clear_raw),
        .toggle         (toggle),
        .clear          (clear)
    );

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_pats();
        for (int i = 0; i < 64; i++) begin
            tog_pat[i] = 1'b0;
            clr_pat[i] = 1'b0;
            rst_pat[i] = 1'b0;
        end
    endtask

    // Play n edges of the pattern tables, recording pulse counts and edges.
    task automatic run(input int n);
        tog_cnt  = 0;
        tog_edge = -1;
        clr_cnt  = 0;
        clr_edge = -1;
        for (int e = 0; e < n; e++) begin
            btn_toggle_raw = tog_pat[e];
            btn_clear_raw  = clr_pat[e];
            reset          = rst_pat[e];
            @(posedge clk);
            #1;
            if (toggle === 1'b1) begin
                if (tog_cnt == 0) tog_edge = e;
                tog_cnt++;
            end
            if (clear === 1'b1) begin
                if (clr_cnt == 0) clr_edge = e;
                clr_cnt++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic check_run(input string tag, input int exp_tog_edge, input int exp_clr_edge);
        check_val({tag, "_tog_count"}, tog_cnt, (exp_tog_edge >= 0) ? 1 : 0);
        check_val({tag, "_tog_edge"},  tog_edge, exp_tog_edge);
        check_val({tag, "_clr_count"}, clr_cnt, (exp_clr_edge >= 0) ? 1 : 0);
        check_val({tag, "_clr_edge"},  clr_edge, exp_clr_edge);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        btn_toggle_raw = 1'b0;
        btn_clear_raw  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_toggle", int'(toggle), 0);
        check_val("rst_clear",  int'(clear), 0);
        check_val("rst_tog_state", int'(dut.u_tog_chan.state_r), int'(IDLE));
        check_val("rst_clr_state", int'(dut.u_clr_chan.state_r), int'(IDLE));
        reset = 1'b0;
        clear_pats();
    endtask

    initial begin
        reset          = 1'b1;
        btn_toggle_raw = 1'b0;
        btn_clear_raw  = 1'b0;
        clear_pats();

        // Clean hold for 40 edges: one toggle at 7; long-press clear at 23 if built in.
        do_reset();
        for (int i = 0; i < 40; i++) tog_pat[i] = 1'b1;
        run(40);
        check_run("hold", 7, HOLD40_CLR_EDGE);

        // High for only 3 cycles: rejected.
        do_reset();
        for (int i = 0; i < 3; i++) tog_pat[i] = 1'b1;
        run(20);
        check_run("short", -1, -1);

        // Press bounce: 5 x (high 2, low 1), steady high from edge 15 -> pulse at 22.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tog_pat[3*k]   = 1'b1;
            tog_pat[3*k+1] = 1'b1;
        end
        for (int i = 15; i < 28; i++) tog_pat[i] = 1'b1;
        run(28);
        check_run("bounce", 22, -1);

        // Release bounce: low 2, high 1, then low -> no second pulse, back to IDLE.
        do_reset();
        for (int i = 0; i < 10; i++) tog_pat[i] = 1'b1;
        tog_pat[12] = 1'b1;
        run(30);
        check_run("relbnc", 7, -1);
        check_val("relbnc_state", int'(dut.u_tog_chan.state_r), int'(IDLE));
        clear_pats();
        for (int i = 0; i < 10; i++) tog_pat[i] = 1'b1;
        run(12);
        check_run("repress", 7, -1);

        // Both buttons rise together: both pulses at edge 7.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tog_pat[i] = 1'b1;
            clr_pat[i] = 1'b1;
        end
        run(20);
        check_run("both", 7, 7);

        // Clear button held: exactly one clear pulse at 7.
        do_reset();
        for (int i = 0; i < 30; i++) clr_pat[i] = 1'b1;
        run(30);
        check_run("clrhold", -1, 7);

        // Reset at edges 5..6 mid-press; first edge out of reset is 7 -> pulse at 14.
        do_reset();
        for (int i = 0; i < 24; i++) tog_pat[i] = 1'b1;
        rst_pat[5] = 1'b1;
        rst_pat[6] = 1'b1;
        run(24);
        check_run("rstmid", 14, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_button_conditioner
